mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
Multi-cycle sequencer and accumulator for the M-extension MUL/MULH/MULHSU/MULHU datapath, sitting between the execute-stage issue logic and the 11x11 partial-product slice. Accepts 32-bit operands, forms sign-magnitude operands and slices them into 11-bit limbs. Steps the limb pairs through the external partial-product slice one per cycle, accumulates the shifted 64-bit products and applies the final sign fix. Returns the selected 32-bit half over a valid/ready handshake.

Parameters:
XLEN, 32, operand width.
SLICE_W, 11, limb width presented to the partial-product slice.
NSLICE, 3, limbs per operand, ceil(XLEN/SLICE_W); top limb is bits 31:22, zero-extended.

Ports:
CLK  in  1  clock.
RST_N  in  1  asynchronous active-low reset.
IN_VALID  in  1  request valid.
IN_READY  out  1  high only in IDLE.
OP  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
RS1  in  32  multiplicand.
RS2  in  32  multiplier.
KILL  in  1  synchronous flush; drops any in-flight or pending result.
PP_EN  out  1  enable to the partial-product slice.
PP_RS1  out  11  rs1 magnitude limb.
PP_RS2  out  11  rs2 magnitude limb.
PP_PROD  in  64  unsigned limb product returned combinationally by the slice.
OUT_VALID  out  1  result valid.
OUT_READY  in  1  consumer ready.
RESULT  out  32  product half selected by OP.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, acc=0, cnt=0, RESULT=0, OUT_VALID=0, PP_EN=0, PP_RS1=0, PP_RS2=0; IN_READY=1 once state=IDLE.
- States: IDLE, RUN, FIX, DONE.
- IDLE: accept on IN_VALID&&IN_READY.
  - Latch |RS1| and |RS2| as 32-bit unsigned; 0x80000000 maps to 2^31.
  - Treat RS1 as signed for OP 01/10; treat RS2 as signed for OP 01 only.
  - neg = (s1 & RS1[31]) ^ (s2 & RS2[31]); MUL uses unsigned treatment, low half is identical.
  - Latch OP; acc=0, cnt=0; go to RUN.
- RUN: PP_EN=1, i=cnt/3, j=cnt%3.
  - PP_RS1 = limb i of |rs1|; PP_RS2 = limb j of |rs2|.
  - Each edge: acc += PP_PROD << (SLICE_W*(i+j)), 64-bit, excess bits truncated.
  - cnt increments; after cnt=8 (9 accumulations) go to FIX.
  - PP_EN=0 and PP_RS1/PP_RS2=0 in all other states.
- FIX: p = neg ? (~acc+1) : acc.
  - RESULT <= p[31:0] for OP 00, else p[63:32]; go to DONE.
- DONE: OUT_VALID=1, RESULT held stable; on OUT_READY go to IDLE, OUT_VALID drops next cycle.
- Latency: OUT_VALID high after the 11th rising edge counting the accept edge as edge 1; throughput one op per 12 cycles minimum.
- IN_READY is 0 in RUN/FIX/DONE; IN_VALID there is ignored, not queued.
- KILL has priority over every transition: next edge returns to IDLE, OUT_VALID=0, acc cleared, RESULT retains its last value.
- KILL and IN_VALID together in IDLE: no accept.
- Reset asserted mid-operation: immediate IDLE, all outputs take their reset values, no result produced.

Optional Feature:
MUL_ZERO_SKIP_EN:
- Defined: in IDLE, if either latched magnitude is zero, go directly to DONE with RESULT=0; OUT_VALID rises after the accept edge (latency 1), PP_EN never asserts.
- Undefined: all operations take the full RUN/FIX path.

Decomposition:
- Shared mul_pkg holds:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - mul_state_e enum (IDLE, RUN, FIX, DONE).
  - XLEN, SLICE_W, NSLICE constants.
  - Limb-shift lookup function.
- One sub-module, mul_sign_prep (combinational): OP, RS1, RS2 -> two 32-bit magnitudes and neg.

Test Plan:
- Bench models PP_PROD as the unsigned 11x11 product of PP_RS1/PP_RS2.
- MUL RS1=7, RS2=6 -> RESULT=0x0000002A; OUT_VALID after 11th edge; exactly 9 cycles of PP_EN.
- MULH RS1=RS2=0x80000000 -> RESULT=0x40000000.
- MULHSU RS1=0xFFFFFFFF, RS2=0xFFFFFFFF -> RESULT=0xFFFFFFFF. MULHU same operands -> RESULT=0xFFFFFFFE.
- OUT_READY held low 5 cycles in DONE -> OUT_VALID and RESULT stable; IN_VALID pulses ignored; accept resumes cycle after handshake.
- KILL on 4th RUN cycle -> no OUT_VALID, IN_READY=1 next cycle. RST_N low mid-RUN -> outputs zero immediately. Next MUL 3x5 -> 0x0000000F.
- MUL_ZERO_SKIP_EN defined, MUL RS1=0, RS2=0x1234 -> OUT_VALID after 1 edge, RESULT=0, PP_EN never high.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential M-extension multiplier.
// Holds the operation and state encodings, the operand/limb geometry,
// and helpers that map the step counter onto limb indices and limb
// shift amounts.
// Optional feature macro used elsewhere in this slice: MUL_ZERO_SKIP_EN.
package mul_pkg;

    localparam int XLEN    = 32;
    localparam int SLICE_W = 11;
    localparam int NSLICE  = 3;
    localparam int ACC_W   = 2 * XLEN;

    // Counter value of the final limb-pair step (NSLICE*NSLICE steps, from 0).
    localparam logic [3:0] LAST_CNT = 4'(NSLICE * NSLICE - 1);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    // Bit offset of limb position idx (0..4, i.e. i+j of a limb pair).
    function automatic logic [5:0] limb_shift(input logic [2:0] idx);
        logic [5:0] sh;
        case (idx)
            3'd0:    sh = 6'd0;
            3'd1:    sh = 6'd11;
            3'd2:    sh = 6'd22;
            3'd3:    sh = 6'd33;
            3'd4:    sh = 6'd44;
            default: sh = 6'd0;
        endcase
        return sh;
    endfunction

    // Limb idx of a 32-bit magnitude; the top limb is only 10 bits wide
    // and comes out zero-extended because of the right shift.
    function automatic logic [SLICE_W-1:0] limb_of(input logic [XLEN-1:0] mag,
                                                   input logic [1:0]      idx);
        logic [XLEN-1:0] sh;
        sh = mag >> limb_shift({1'b0, idx});
        return sh[SLICE_W-1:0];
    endfunction

    // Step counter -> {i, j} with i = cnt/3 (rs1 limb) and j = cnt%3 (rs2 limb).
    function automatic logic [3:0] cnt_ij(input logic [3:0] cnt);
        logic [3:0] ij;
        case (cnt)
            4'd0:    ij = 4'b00_00;
            4'd1:    ij = 4'b00_01;
            4'd2:    ij = 4'b00_10;
            4'd3:    ij = 4'b01_00;
            4'd4:    ij = 4'b01_01;
            4'd5:    ij = 4'b01_10;
            4'd6:    ij = 4'b10_00;
            4'd7:    ij = 4'b10_01;
            4'd8:    ij = 4'b10_10;
            default: ij = 4'b00_00;
        endcase
        return ij;
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Bundle of the request, partial-product slice and response signals of
// mul_seq. The slave modport is the sequencer's view; the master modport
// is the view of the surrounding issue logic / slice / consumer.
//   in_valid/in_ready/op/rs1/rs2 : request handshake and operands
//   kill                         : synchronous flush
//   pp_en/pp_rs1/pp_rs2/pp_prod  : partial-product slice port
//   out_valid/out_ready/result   : response handshake
interface mul_seq_if;
    import mul_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic                 kill;
    logic                 pp_en;
    logic [SLICE_W-1:0]   pp_rs1;
    logic [SLICE_W-1:0]   pp_rs2;
    logic [ACC_W-1:0]     pp_prod;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      result;

    modport slave (
        input  in_valid, op, rs1, rs2, kill, pp_prod, out_ready,
        output in_ready, pp_en, pp_rs1, pp_rs2, out_valid, result
    );

    modport master (
        output in_valid, op, rs1, rs2, kill, pp_prod, out_ready,
        input  in_ready, pp_en, pp_rs1, pp_rs2, out_valid, result
    );

endinterface

// File: rtl/mul_sign_prep.sv
// Combinational operand preparation: decides which operands are signed
// for the given op, forms their 32-bit unsigned magnitudes and the sign
// of the final product.
//   op_i   : operation (MUL, MULH, MULHSU, MULHU)
//   rs1_i  : multiplicand
//   rs2_i  : multiplier
//   mag1_o : |rs1| (0x80000000 stays 0x80000000, i.e. 2^31)
//   mag2_o : |rs2|
//   neg_o  : product must be negated
module mul_sign_prep
    import mul_pkg::*;
(
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] mag1_o,
    output logic [XLEN-1:0] mag2_o,
    output logic            neg_o
);

    logic s1_s;
    logic s2_s;
    logic n1_s;
    logic n2_s;

    // Signedness per op; MUL is treated unsigned since its low half is identical.
    always_comb begin
        s1_s = 1'b0;
        s2_s = 1'b0;
        case (op_i)
            OP_MUL:    begin s1_s = 1'b0; s2_s = 1'b0; end
            OP_MULH:   begin s1_s = 1'b1; s2_s = 1'b1; end
            OP_MULHSU: begin s1_s = 1'b1; s2_s = 1'b0; end
            OP_MULHU:  begin s1_s = 1'b0; s2_s = 1'b0; end
            default:   begin s1_s = 1'b0; s2_s = 1'b0; end
        endcase
    end

    // Magnitudes and product sign.
    always_comb begin
        n1_s = s1_s & rs1_i[XLEN-1];
        n2_s = s2_s & rs2_i[XLEN-1];
        if (n1_s) begin
            mag1_o = ~rs1_i + 32'd1;
        end else begin
            mag1_o = rs1_i;
        end
        if (n2_s) begin
            mag2_o = ~rs2_i + 32'd1;
        end else begin
            mag2_o = rs2_i;
        end
        neg_o = n1_s ^ n2_s;
    end

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle sequencer/accumulator for MUL/MULH/MULHSU/MULHU.
// Steps the nine limb pairs of |rs1| x |rs2| through an external 11x11
// partial-product slice (one pair per cycle), accumulates the shifted
// products, applies the sign fix and returns the selected 32-bit half.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mul_seq_if.slave (request, kill, slice port, response)
// Optional feature: define MUL_ZERO_SKIP_EN to finish immediately (result 0,
// no slice activity) when either operand magnitude is zero.
module mul_seq
    import mul_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mul_seq_if.slave  bus
);

    mul_state_e          state_q;
    logic [XLEN-1:0]     mag1_q;
    logic [XLEN-1:0]     mag2_q;
    logic                neg_q;
    logic [1:0]          op_q;
    logic [ACC_W-1:0]    acc_q;
    logic [3:0]          cnt_q;
    logic [XLEN-1:0]     result_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                pp_en_q;
    logic [SLICE_W-1:0]  pp_rs1_q;
    logic [SLICE_W-1:0]  pp_rs2_q;

    logic [XLEN-1:0]     mag1_s;
    logic [XLEN-1:0]     mag2_s;
    logic                neg_s;
    logic                zero_s;
    logic [3:0]          cnt_d;
    logic [3:0]          ij_cur_s;
    logic [3:0]          ij_nxt_s;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    fixed_s;

    mul_sign_prep u_sign_prep (
        .op_i   (bus.op),
        .rs1_i  (bus.rs1),
        .rs2_i  (bus.rs2),
        .mag1_o (mag1_s),
        .mag2_o (mag2_s),
        .neg_o  (neg_s)
    );

`ifdef MUL_ZERO_SKIP_EN
    assign zero_s = (mag1_s == 32'd0) || (mag2_s == 32'd0);
`else
    assign zero_s = 1'b0;
`endif

    // Accumulate step for the current limb pair and the sign-fixed product.
    always_comb begin
        cnt_d    = cnt_q + 4'd1;
        ij_cur_s = cnt_ij(cnt_q);
        ij_nxt_s = cnt_ij(cnt_d);
        acc_d    = acc_q + (bus.pp_prod <<
                            limb_shift({1'b0, ij_cur_s[3:2]} + {1'b0, ij_cur_s[1:0]}));
        if (neg_q) begin
            fixed_s = ~acc_q + 64'd1;
        end else begin
            fixed_s = acc_q;
        end
    end

    // Sequencer FSM with all outputs registered; KILL overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mag1_q      <= 32'd0;
            mag2_q      <= 32'd0;
            neg_q       <= 1'b0;
            op_q        <= 2'b00;
            acc_q       <= 64'd0;
            cnt_q       <= 4'd0;
            result_q    <= 32'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            pp_en_q     <= 1'b0;
            pp_rs1_q    <= 11'd0;
            pp_rs2_q    <= 11'd0;
        end else if (bus.kill) begin
            // RESULT deliberately keeps its last value.
            state_q     <= ST_IDLE;
            acc_q       <= 64'd0;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            pp_en_q     <= 1'b0;
            pp_rs1_q    <= 11'd0;
            pp_rs2_q    <= 11'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        mag1_q     <= mag1_s;
                        mag2_q     <= mag2_s;
                        neg_q      <= neg_s;
                        op_q       <= bus.op;
                        acc_q      <= 64'd0;
                        cnt_q      <= 4'd0;
                        in_ready_q <= 1'b0;
                        if (zero_s) begin
                            state_q     <= ST_DONE;
                            result_q    <= 32'd0;
                            out_valid_q <= 1'b1;
                        end else begin
                            // Present the first limb pair in the first RUN cycle.
                            state_q  <= ST_RUN;
                            pp_en_q  <= 1'b1;
                            pp_rs1_q <= limb_of(mag1_s, 2'd0);
                            pp_rs2_q <= limb_of(mag2_s, 2'd0);
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= ST_FIX;
                        pp_en_q  <= 1'b0;
                        pp_rs1_q <= 11'd0;
                        pp_rs2_q <= 11'd0;
                    end else begin
                        // Limbs for the following step are staged one cycle ahead.
                        pp_rs1_q <= limb_of(mag1_q, ij_nxt_s[3:2]);
                        pp_rs2_q <= limb_of(mag2_q, ij_nxt_s[1:0]);
                    end
                end
                ST_FIX: begin
                    if (op_q == OP_MUL) begin
                        result_q <= fixed_s[XLEN-1:0];
                    end else begin
                        result_q <= fixed_s[ACC_W-1:XLEN];
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    pp_en_q     <= 1'b0;
                    pp_rs1_q    <= 11'd0;
                    pp_rs2_q    <= 11'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.pp_en     = pp_en_q;
    assign bus.pp_rs1    = pp_rs1_q;
    assign bus.pp_rs2    = pp_rs2_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed cases plus randomized ops
// checked against an arithmetic reference model and a per-cycle monitor.
module tb_mul_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul_seq_if bus ();

    mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Partial-product slice: unsigned 11x11 product.
    logic [21:0] pp_small;
    assign pp_small    = 22'(bus.pp_rs1) * 22'(bus.pp_rs2);
    assign bus.pp_prod = {42'd0, pp_small};

    typedef struct {
        logic [1:0]  op;
        logic [31:0] m1;
        logic [31:0] m2;
        logic [31:0] exp;
        int          acc_cyc;
        bit          zs;
    } txn_t;

    txn_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Reference: full-precision signed/unsigned product, then pick the half.
    function automatic logic [31:0] model_result(input logic [1:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        sa = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
        sb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] abs_of(input bit s, input logic [31:0] x);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic txn_t make_txn(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input int c);
        txn_t t;
        t.op      = op;
        t.m1      = abs_of(op == 2'b01 || op == 2'b10, a);
        t.m2      = abs_of(op == 2'b01, b);
        t.exp     = model_result(op, a, b);
        t.acc_cyc = c;
`ifdef MUL_ZERO_SKIP_EN
        t.zs      = (t.m1 == 32'd0) || (t.m2 == 32'd0);
`else
        t.zs      = 1'b0;
`endif
        return t;
    endfunction

    // Monitor: limb schedule, result, latency, PP_EN count and DONE stability.
    initial begin
        logic        prev_v;
        logic        prev_pp;
        logic [31:0] prev_r;
        int          pp_seen;
        prev_v  = 1'b0;
        prev_pp = 1'b0;
        prev_r  = 32'd0;
        pp_seen = 0;
        forever begin
            @(negedge clk);
            if (bus.pp_en) begin
                if (!prev_pp) pp_seen = 0;
                if (q.size() == 0) begin
                    check("pp_en_unexpected", bus.pp_en, 64'd0);
                end else begin
                    check("pp_rs1_limb", bus.pp_rs1,
                          (q[0].m1 >> (11 * (pp_seen / 3))) & 32'h7FF);
                    check("pp_rs2_limb", bus.pp_rs2,
                          (q[0].m2 >> (11 * (pp_seen % 3))) & 32'h7FF);
                end
                pp_seen++;
            end
            if (bus.out_valid) begin
                if (!prev_v) begin
                    if (q.size() == 0) begin
                        check("out_valid_unexpected", bus.out_valid, 64'd0);
                    end else begin
                        check("result", bus.result, q[0].exp);
                        check("latency_edges", cyc - q[0].acc_cyc + 1, q[0].zs ? 1 : 11);
                        check("pp_en_cycles", pp_seen, q[0].zs ? 0 : 9);
                    end
                    pp_seen = 0;
                end else begin
                    check("result_stable", bus.result, prev_r);
                end
                if (bus.out_ready && q.size() > 0) void'(q.pop_front());
            end
            prev_v  = bus.out_valid;
            prev_pp = bus.pp_en;
            prev_r  = bus.result;
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 64'd1);
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        q.push_back(make_txn(op, a, b, cyc));
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit pulse, output logic [31:0] got);
        int w;
        accept(op, a, b);
        w = 0;
        while (!bus.out_valid && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.out_valid) check("out_valid_timeout", bus.out_valid, 64'd1);
        got = bus.result;
        for (int k = 0; k < hold; k++) begin
            if (pulse) begin
                bus.in_valid = 1'b1;
                bus.rs1      = $urandom;
            end
            check("in_ready_low_in_done", bus.in_ready, 64'd0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_handshake", bus.in_ready, 64'd1);
        check("out_valid_after_handshake", bus.out_valid, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.rs1       = 32'd0;
        bus.rs2       = 32'd0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 64'd1);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_pp_en", bus.pp_en, 64'd0);
        check("rst_pp_rs1", bus.pp_rs1, 64'd0);
        check("rst_pp_rs2", bus.pp_rs2, 64'd0);
        check("rst_result", bus.result, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 32'd7, 32'd6, 0, 1'b0, got);
        check("mul_7x6", got, 64'h2A);
        run_op(2'b01, 32'h80000000, 32'h80000000, 0, 1'b0, got);
        check("mulh_min_min", got, 64'h40000000);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, got);
        check("mulhsu_m1", got, 64'hFFFFFFFF);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, got);
        check("mulhu_max", got, 64'hFFFFFFFE);
        run_op(2'b00, 32'h1234, 32'h5678, 5, 1'b1, got);
        check("mul_hold5", got, 64'h06260060);

        // KILL during the 4th RUN cycle.
        accept(2'b00, 32'h12345, 32'h777);
        repeat (3) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        q.delete();
        check("kill_in_ready", bus.in_ready, 64'd1);
        check("kill_out_valid", bus.out_valid, 64'd0);
        check("kill_pp_en", bus.pp_en, 64'd0);
        check("kill_result_kept", bus.result, 64'h06260060);
        repeat (15) begin @(posedge clk); #1; end
        check("kill_no_result", bus.out_valid, 64'd0);

        // Reset asserted in the middle of RUN.
        accept(2'b01, 32'hDEADBEEF, 32'h01234567);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_pp_en", bus.pp_en, 64'd0);
        check("mid_rst_pp_rs1", bus.pp_rs1, 64'd0);
        check("mid_rst_pp_rs2", bus.pp_rs2, 64'd0);
        check("mid_rst_out_valid", bus.out_valid, 64'd0);
        check("mid_rst_result", bus.result, 64'd0);
        check("mid_rst_in_ready", bus.in_ready, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 32'd3, 32'd5, 0, 1'b0, got);
        check("mul_3x5", got, 64'hF);
        run_op(2'b00, 32'd0, 32'h1234, 0, 1'b0, got);
        check("mul_zero", got, 64'd0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       a = 32'd0;
                1:       a = 32'h80000000;
                2:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'h80000000;
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), got);
            check("rand_result", got, model_result(op, a, b));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
